// File: rtl/seq_controller.sv
// Instruction sequencer: walks each instruction class through (phase, step) pairs,
// stalling on memory steps, resolving conditional jumps and trapping illegal opcodes.
module seq_controller #(
    parameter int IW       = 8,
    parameter int MEM_WAIT = 1,
    parameter int FW       = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] I,
    input  logic [FW-1:0] flags,
    input  logic          mem_ready,
    input  logic          run,
    output logic [3:0]    phase,
    output logic [2:0]    step,
    output logic          mem_req,
    output logic          take,
    output logic          end_sq,
    output logic          pause_cc,
    output logic          halted,
    output logic          illegal
);

    typedef enum logic [3:0] {
        PH_RST   = 4'd0,
        PH_FETCH = 4'd1,
        PH_MOV   = 4'd2,
        PH_ALU   = 4'd3,
        PH_UNARY = 4'd4,
        PH_LD    = 4'd5,
        PH_ST    = 4'd6,
        PH_JMP   = 4'd7,
        PH_JCC   = 4'd8,
        PH_HALT  = 4'd9,
        PH_ILL   = 4'd10
    } phase_e;

    localparam logic WAIT_EN = (MEM_WAIT != 0);

    phase_e     phase_q;
    logic [2:0] step_q;
    logic       illegal_q;
    logic [2:0] mask_q;
    logic       neg_q;

    logic [7:0] opcode;
    phase_e     dec_phase;
    logic [2:0] dec_mask;
    logic       dec_neg;
    logic [2:0] last_step;
    logic       mem_step;
    logic       advance;

    assign opcode = I[IW-1 -: 8];

    always_comb begin
        dec_phase = PH_ILL;
        dec_mask  = opcode[3:1];
        dec_neg   = opcode[0];
        casez (opcode)
            8'b0000_????:             dec_phase = PH_MOV;
            8'b0010_????, 8'b0011_00??,
            8'b0011_01??, 8'b0011_11??: dec_phase = PH_ALU;
            8'b0100_00??, 8'b0100_01??,
            8'b0101_00??:             dec_phase = PH_UNARY;
            8'b1000_00??:             dec_phase = PH_LD;
            8'b1010_??00:             dec_phase = PH_ST;
            8'b1100_0000:             dec_phase = PH_JMP;
            8'b1110_????:             dec_phase = (opcode[3:1] == 3'b000) ? PH_ILL : PH_JCC;
            8'b1111_0000: begin
                dec_phase = PH_JCC;
                dec_mask  = 3'b100;
                dec_neg   = 1'b0;
            end
            8'b1111_1111:             dec_phase = PH_HALT;
            default:                  dec_phase = PH_ILL;
        endcase
    end

    always_comb begin
        last_step = 3'd0;
        mem_step  = 1'b0;
        case (phase_q)
            PH_FETCH: begin last_step = 3'd2; mem_step = (step_q == 3'd1); end
            PH_MOV:   last_step = 3'd0;
            PH_ALU:   last_step = 3'd2;
            PH_UNARY: last_step = 3'd1;
            PH_LD:    begin last_step = 3'd4; mem_step = (step_q == 3'd1) || (step_q == 3'd3); end
            PH_ST:    begin last_step = 3'd4; mem_step = (step_q == 3'd1) || (step_q == 3'd4); end
            PH_JMP:   begin last_step = 3'd2; mem_step = (step_q == 3'd1); end
            PH_JCC:   begin last_step = 3'd2; mem_step = (step_q == 3'd1); end
            default:  begin last_step = 3'd0; mem_step = 1'b0; end
        endcase
    end

    // Handshake: mem_req is held for the whole memory step; the step completes on the
    // first cycle mem_ready is high while mem_req is high (mem_ready ignored otherwise).
    assign advance = !mem_step || !WAIT_EN || mem_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q   <= PH_RST;
            step_q    <= 3'd0;
            illegal_q <= 1'b0;
            mask_q    <= 3'd0;
            neg_q     <= 1'b0;
        end else begin
            case (phase_q)
                PH_RST: begin
                    phase_q <= PH_FETCH;
                    step_q  <= 3'd0;
                end
                PH_HALT: begin
                    if (run) begin
                        phase_q <= PH_FETCH;
                        step_q  <= 3'd0;
                    end
                end
                PH_ILL: begin
                    phase_q <= PH_ILL;
                end
                PH_FETCH: begin
                    if (advance) begin
                        if (step_q == last_step) begin
                            phase_q <= dec_phase;
                            step_q  <= 3'd0;
                            mask_q  <= dec_mask;
                            neg_q   <= dec_neg;
                            if (dec_phase == PH_ILL) begin
                                illegal_q <= 1'b1;
                            end
                        end else begin
                            step_q <= step_q + 3'd1;
                        end
                    end
                end
                default: begin
                    if (advance) begin
                        if (step_q == last_step) begin
                            phase_q <= PH_FETCH;
                            step_q  <= 3'd0;
                        end else begin
                            step_q <= step_q + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign phase    = phase_q;
    assign step     = step_q;
    assign mem_req  = mem_step;
    assign halted   = (phase_q == PH_HALT) || (phase_q == PH_ILL);
    assign illegal  = illegal_q;
    assign end_sq   = (phase_q inside {PH_MOV, PH_ALU, PH_UNARY, PH_LD, PH_ST, PH_JMP, PH_JCC})
                      && (step_q == last_step);
    assign pause_cc = halted || (mem_step && WAIT_EN && !mem_ready);
    assign take     = (phase_q == PH_JCC) && (step_q == 3'd2)
                      && (neg_q ^ |(mask_q & flags[2:0]));

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: drives random and directed instruction streams and checks
// every cycle against a table-driven model of the instruction classes.
module tb_seq_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] I = 8'h00;
    logic [2:0] flags = 3'b000;
    logic       mem_ready = 1'b0;
    logic       run = 1'b0;
    logic [3:0] phase;
    logic [2:0] step;
    logic       mem_req, take, end_sq, pause_cc, halted, illegal;
    logic [13:0] obs;
    logic [13:0] exp_v;

    int n_checks = 0;
    int n_fail = 0;
    int ld_cycles = 0;

    seq_controller #(.IW(8), .MEM_WAIT(1), .FW(3)) dut (
        .clock(clock), .reset(reset), .I(I), .flags(flags), .mem_ready(mem_ready), .run(run),
        .phase(phase), .step(step), .mem_req(mem_req), .take(take), .end_sq(end_sq),
        .pause_cc(pause_cc), .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign obs = {phase, step, mem_req, take, end_sq, pause_cc, halted, illegal};

    function automatic logic [13:0] pack(int ph, int st, logic mr, logic tk, logic es,
                                         logic pc, logic hl, logic il);
        logic [3:0] p4;
        logic [2:0] s3;
        p4 = ph[3:0];
        s3 = st[2:0];
        return {p4, s3, mr, tk, es, pc, hl, il};
    endfunction

    // Instruction class from the opcode table, phrased as nibble arithmetic.
    function automatic int ref_class(logic [7:0] op);
        int hi, lo;
        hi = int'(op[7:4]);
        lo = int'(op[3:0]);
        if (hi == 0) return 2;
        if (hi == 2) return 3;
        if (hi == 3 && (lo / 4) != 2) return 3;
        if (hi == 4 && (lo / 4) < 2) return 4;
        if (hi == 5 && (lo / 4) == 0) return 4;
        if (hi == 8 && lo < 4) return 5;
        if (hi == 10 && (lo % 4) == 0) return 6;
        if (op == 8'hC0) return 7;
        if (hi == 14 && (lo / 2) != 0) return 8;
        if (op == 8'hF0) return 8;
        if (op == 8'hFF) return 9;
        return 10;
    endfunction

    function automatic int ref_len(int cls);
        case (cls)
            1: return 3;
            2: return 1;
            3: return 3;
            4: return 2;
            5: return 5;
            6: return 5;
            7: return 3;
            8: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_mem(int cls, int st);
        case (cls)
            1, 7, 8: return st == 1;
            5:       return st == 1 || st == 3;
            6:       return st == 1 || st == 4;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_take(logic [7:0] op, logic [2:0] flg);
        int mask, neg, hit;
        mask = (op == 8'hF0) ? 4 : int'(op[3:1]);
        neg  = (op == 8'hF0) ? 0 : int'(op[0]);
        hit  = 0;
        if ((mask / 4) % 2 == 1 && flg[2]) hit = 1;
        if ((mask / 2) % 2 == 1 && flg[1]) hit = 1;
        if (mask % 2 == 1 && flg[0]) hit = 1;
        return (neg != hit);
    endfunction

    // Runs one instruction from FETCH/0; s1_stall>=0 fixes stalls at instruction step 1 and
    // zero elsewhere; abort_st>=0 raises reset after checking that instruction step.
    task automatic run_instr(input logic [7:0] op, input logic [2:0] flg,
                             input int s1_stall, input int abort_st);
        int cls, n_steps, stalls, ph, st;
        logic mem, tk, es;
        cls = ref_class(op);
        I = op;
        flags = flg;
        n_steps = 3 + ref_len(cls);
        ld_cycles = 0;
        for (int k = 0; k < n_steps; k++) begin
            if (k < 3) begin ph = 1; st = k; end
            else begin ph = cls; st = k - 3; end
            mem = ref_mem(ph, st);
            if (!mem) stalls = 0;
            else if (s1_stall < 0) stalls = $urandom_range(0, 2);
            else stalls = (ph != 1 && st == 1) ? s1_stall : 0;
            tk = (ph == 8 && st == 2) ? ref_take(op, flg) : 1'b0;
            es = (ph != 1) && (st == ref_len(ph) - 1);
            for (int s = 0; s <= stalls; s++) begin
                @(negedge clock);
                mem_ready = mem ? (s == stalls) : 1'($urandom_range(0, 1));
                run = 1'($urandom_range(0, 1));
                #1;
                if (phase === 4'd5) ld_cycles++;
                exp_v = pack(ph, st, mem, tk, es, mem && (s != stalls), 1'b0, 1'b0);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL instr op=%02h ph=%0d st=%0d: got %04h want %04h", op, ph, st, obs, exp_v);
                end
                if (ph != 1 && st == abort_st) begin
                    reset = 1'b1;
                    run = 1'b0;
                    return;
                end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            #1;
            n_checks++;
            if (obs !== 14'h0) begin
                n_fail++;
                $display("FAIL reset_hold: got %04h want %04h", obs, 14'h0);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %04h want %04h", obs, 14'h0);
        end
        run_instr(8'h01, 3'b000, 0, -1);
    endtask

    task automatic test_ld_stall();
        run_instr(8'h80, 3'b000, 3, -1);
        n_checks++;
        if (ld_cycles !== 8) begin
            n_fail++;
            $display("FAIL ld_phase_cycles: got %0d want %0d", ld_cycles, 8);
        end
    endtask

    task automatic test_jcc();
        logic [7:0] ops [4];
        ops[0] = 8'hE5;
        ops[1] = 8'hE9;
        ops[2] = 8'hF0;
        ops[3] = 8'hE0 | 8'($urandom_range(2, 15));
        for (int i = 0; i < 4; i++) begin
            for (int f = 0; f < 8; f++) begin
                run_instr(ops[i], 3'(f), -1, -1);
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] op;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) op = 8'h38;
            else begin
                do op = 8'($urandom_range(0, 255)); while (ref_class(op) != 10);
            end
            run_instr(op, 3'($urandom_range(0, 7)), -1, -1);
            for (int c = 0; c < 3; c++) begin
                @(negedge clock);
                run = (c == 1);
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                exp_v = pack(10, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL ill_hold op=%02h c=%0d: got %04h want %04h", op, c, obs, exp_v);
                end
            end
            @(negedge clock);
            run = 1'b0;
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            #1;
            n_checks++;
            if (obs !== 14'h0) begin
                n_fail++;
                $display("FAIL ill_reset op=%02h: got %04h want %04h", op, obs, 14'h0);
            end
        end
    endtask

    task automatic test_halt();
        run_instr(8'hFF, 3'b000, -1, -1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            run = (c == 3);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            exp_v = pack(9, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL halt_hold c=%0d: got %04h want %04h", c, obs, exp_v);
            end
        end
        run_instr(8'h07, 3'b000, -1, -1);
    endtask

    task automatic test_reset_mid();
        run_instr(8'hA0, 3'b000, -1, 3);
        mem_ready = 1'b1;
        run = 1'b1;
        @(negedge clock);
        #1;
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_mid_st: got %04h want %04h", obs, 14'h0);
        end
        reset = 1'b0;
        run = 1'b0;
        run_instr(8'h24, 3'b000, -1, -1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] op;
        for (int i = 0; i < 40; i++) begin
            do op = 8'($urandom_range(0, 255)); while (ref_class(op) >= 9);
            run_instr(op, 3'($urandom_range(0, 7)), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_ld_stall();
        test_jcc();
        test_illegal();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
